pll_reset_sequencer: RTL

Sequences the reset handshake with the system PLL: drives the PLL `rst` input and reads back its asynchronous `locked` output. It holds the downstream clock domains in reset until lock has been stable for a programmable interval. It also detects lock loss and lock timeouts and re-issues a PLL reset. The block runs on the free-running 50 MHz board reference clock, which is the same clock that feeds the PLL `refclk`, because the PLL outputs are not valid before lock.

---
 rtl/pll_seq_pkg.sv | 33 +++
 rtl/bit_sync.sv | 43 ++++
 rtl/pll_reset_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : pll_seq_pkg
// Brief    : Shared types and default timing constants for the PLL reset sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLLRST    = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    // Defaults assume the 50 MHz board reference clock.
    localparam int unsigned c_def_sync_stages   = 2;
    localparam int unsigned c_def_rst_pulse     = 500;
    localparam int unsigned c_def_lock_timeout  = 5_000_000;
    localparam int unsigned c_def_stable_cycles = 50_000;
    localparam int unsigned c_def_cnt_w         = 23;

    localparam int unsigned c_retry_w = 4;
    localparam logic [c_retry_w-1:0] c_retry_max = '1;

    function automatic logic [c_retry_w-1:0] sat_inc(input logic [c_retry_w-1:0] value);
        return (value == c_retry_max) ? value : value + c_retry_w'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
//------------------------------------------------------------------------------
// Module   : bit_sync
// Brief    : Multi-flop single-bit synchronizer, asynchronous active-low reset to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= i_d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module   : pll_reset_sequencer
// Brief    : Drives the PLL reset, qualifies lock stability and releases the
//            downstream domains; retries the PLL on lock timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = c_def_sync_stages,
    parameter int unsigned RST_PULSE     = c_def_rst_pulse,
    parameter int unsigned LOCK_TIMEOUT  = c_def_lock_timeout,
    parameter int unsigned STABLE_CYCLES = c_def_stable_cycles,
    parameter int unsigned CNT_W         = c_def_cnt_w
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 req_reset,
    output logic                 pll_rst,
    output logic                 sys_reset_n,
    output logic                 ready,
    output logic                 lock_lost,
    output logic [c_retry_w-1:0] retry_count
);

    localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

    pll_state_t           r_state;
    logic [CNT_W-1:0]     r_timer;
    logic                 r_pll_rst;
    logic                 r_sys_reset_n;
    logic                 r_ready;
    logic                 r_lock_lost;
    logic [c_retry_w-1:0] r_retry_count;
    logic                 w_lk;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_lk)
    );

    // One timer is shared by every state; each transition restarts it at 0.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PLLRST;
            r_timer       <= '0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_ready       <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_retry_count <= '0;
        end else begin
            r_lock_lost <= 1'b0;
            case (r_state)
                PLLRST: begin
                    if (r_timer == c_rst_last) begin
                        r_state   <= WAIT_LOCK;
                        r_timer   <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_timer <= r_timer + c_one;
                    end
                end
                WAIT_LOCK: begin
                    if (w_lk) begin
                        r_state <= STABLE;
                        r_timer <= '0;
                    end else if (r_timer == c_timeout_last) begin
                        r_retry_count <= sat_inc(r_retry_count);
                        r_state       <= PLLRST;
                        r_timer       <= '0;
                        r_pll_rst     <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_one;
                    end
                end
                STABLE: begin
                    // Loss of lock outranks both the soft request and the terminal count.
                    if (!w_lk) begin
                        r_state <= WAIT_LOCK;
                        r_timer <= '0;
                    end else if (req_reset) begin
                        r_timer <= '0;
                    end else if (r_timer == c_stable_last) begin
                        r_state       <= RUN;
                        r_timer       <= '0;
                        r_sys_reset_n <= 1'b1;
                        r_ready       <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_one;
                    end
                end
                RUN: begin
                    if (!w_lk) begin
                        r_state       <= PLLRST;
                        r_timer       <= '0;
                        r_pll_rst     <= 1'b1;
                        r_sys_reset_n <= 1'b0;
                        r_ready       <= 1'b0;
                        r_lock_lost   <= 1'b1;
                    end else if (req_reset) begin
                        r_state       <= STABLE;
                        r_timer       <= '0;
                        r_sys_reset_n <= 1'b0;
                        r_ready       <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= PLLRST;
                    r_timer       <= '0;
                    r_pll_rst     <= 1'b1;
                    r_sys_reset_n <= 1'b0;
                    r_ready       <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_reset_n = r_sys_reset_n;
    assign ready       = r_ready;
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry_count;

endmodule

`default_nettype wire
